rr_arb8: RTL

RR_ARB8 -- requirements
Module: rr_arb8

---
 rtl/rr_arb8.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rr_arb8.sv
// -----------------------------------------------------------------------------
// rr_arb8 -- 8-requester round-robin arbiter with a registered one-hot grant,
// a binary grant index for an 8:1 mux, and a combinational 1-bit data mux.
//
// Ports
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous, active-high reset
//   req      in   8  request per requester (bit i = requester i)
//   data_in  in   8  1-bit data per requester (bit i = requester i)
//   gnt      out  8  one-hot grant, registered (0 when idle)
//   sel      out  3  binary index of the owner, registered
//   busy     out  1  1 while a grant is held, registered
//   data_out out  1  data_in[sel] while busy, else 0 (combinational)
//
// Parameters
//   HOLD_MAX        max consecutive grant cycles per owner (1..15); only
//                   used when RR_ARB8_HOLD_LIMIT_EN is defined.
//
// Build option
//   RR_ARB8_HOLD_LIMIT_EN  builds a 4-bit hold counter that forces
//                          re-arbitration after HOLD_MAX cycles when another
//                          requester is waiting. Undefined by default: an
//                          owner keeps the grant while its req stays high.
// -----------------------------------------------------------------------------
module rr_arb8 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       data_out
);

    localparam int unsigned N_REQ = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Out-of-range HOLD_MAX is a configuration error in either build.
    if (HOLD_MAX == 0 || HOLD_MAX > 15) begin : g_hold_max_check
        $error("rr_arb8: HOLD_MAX must be in 1..15");
    end

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] r_sel;
    logic [2:0] w_sel_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;

    logic [7:0] w_arb_req;
    logic [2:0] w_arb_base;
    logic       w_arb_found;
    logic [2:0] w_arb_idx;
    logic       w_release;
    logic       w_force;

    // First set bit of req_v searching upward from base, wrapping 7->0.
    function automatic logic [3:0] f_rr_pick(input logic [7:0] req_v,
                                             input logic [2:0] base);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = base;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = base + 3'(i);
            if (!found && req_v[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // The owner is masked out so a hold-limit switch never re-picks it; on a
    // release its req bit is already 0, and in IDLE r_gnt is 0.
    assign w_arb_req  = req & ~r_gnt;
    assign w_arb_base = (r_state == ST_GRANT) ? (r_sel + 3'd1) : r_ptr;
    assign {w_arb_found, w_arb_idx} = f_rr_pick(w_arb_req, w_arb_base);

    assign w_release = ~req[r_sel];

`ifdef RR_ARB8_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 32'd1);

    logic [3:0] r_hold_cnt;
    logic [3:0] w_hold_nxt;

    // Limit reached and someone else is waiting.
    assign w_force = (r_hold_cnt == HOLD_LAST) && (w_arb_req != 8'd0);
`else
    assign w_force = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
`ifdef RR_ARB8_HOLD_LIMIT_EN
        w_hold_nxt  = r_hold_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt  = 8'd0;
                w_busy_nxt = 1'b0;
                if (w_arb_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_arb_idx;
                    w_gnt_nxt   = 8'b1 << w_arb_idx;
                    w_busy_nxt  = 1'b1;
`ifdef RR_ARB8_HOLD_LIMIT_EN
                    w_hold_nxt  = 4'd0;
`endif
                end
            end
            ST_GRANT: begin
                if (w_release || w_force) begin
                    // Pointer moves past the outgoing owner before the pick.
                    w_ptr_nxt = r_sel + 3'd1;
                    if (w_arb_found) begin
                        w_sel_nxt  = w_arb_idx;
                        w_gnt_nxt  = 8'b1 << w_arb_idx;
                        w_busy_nxt = 1'b1;
`ifdef RR_ARB8_HOLD_LIMIT_EN
                        w_hold_nxt = 4'd0;
`endif
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 8'd0;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
`ifdef RR_ARB8_HOLD_LIMIT_EN
                    // Saturate so a lone owner keeps the limit armed.
                    if (r_hold_cnt != HOLD_LAST) begin
                        w_hold_nxt = r_hold_cnt + 4'd1;
                    end
`endif
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 8'd0;
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

`ifdef RR_ARB8_HOLD_LIMIT_EN
    // Hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= 4'd0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
        end
    end
`endif

    assign gnt      = r_gnt;
    assign sel      = r_sel;
    assign busy     = r_busy;
    // Gated by reset as well so the mux output is quiet throughout reset.
    assign data_out = r_busy & ~reset & data_in[r_sel];

endmodule
